// File: rtl/controlador_nonce.sv
// controlador_nonce: drives one micro_ucr_hash core to search for a winning nonce.
//   An accepted inicio latches the data block, the target and the starting nonce.
//   Each attempt then presents {bloque_reg, nonce} to the core, waits for
//   hash_terminado (bounded by TIMEOUT_CICLOS), checks the hash against the
//   target, and steps the nonce. The search ends on a hit, when the nonce space
//   is exhausted, on a core timeout, or on abortar.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   inicio, abortar     start request (IDLE only) / cancel (non-IDLE only)
//   bloque_datos,target,nonce_base  search inputs, sampled at acceptance
//   hash_inicio/hash_bloque/hash_terminado/hash_resultado  hash core handshake
//   ocupado, terminado  busy level / one-cycle end-of-search pulse
//   encontrado, agotado, error_timeout  sticky result flags
//   nonce_ganador, hash_ganador, intentos  search results
module controlador_nonce #(
  parameter int NONCE_W        = 32,
  parameter int HASH_W         = 24,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inicio,
  input  logic                    abortar,
  input  logic [95:0]             bloque_datos,
  input  logic [7:0]              target,
  input  logic [NONCE_W-1:0]      nonce_base,
  output logic                    hash_inicio,
  output logic [96+NONCE_W-1:0]   hash_bloque,
  input  logic                    hash_terminado,
  input  logic [HASH_W-1:0]       hash_resultado,
  output logic                    ocupado,
  output logic                    terminado,
  output logic                    encontrado,
  output logic                    agotado,
  output logic                    error_timeout,
  output logic [NONCE_W-1:0]      nonce_ganador,
  output logic [HASH_W-1:0]       hash_ganador,
  output logic [NONCE_W:0]        intentos
);

  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0]      T_LIM   = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [NONCE_W:0]   INT_MAX = {1'b1, {NONCE_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, CARGA, ESPERA, EVALUA} estado_t;

  estado_t              estado, estado_sig;
  logic [95:0]          bloque_reg;
  logic [7:0]           target_reg;
  logic [NONCE_W-1:0]   nonce_base_reg;
  logic [NONCE_W-1:0]   nonce;
  logic [NONCE_W-1:0]   nonce_sig;
  logic [HASH_W-1:0]    hash_reg;
  logic [TW-1:0]        tcnt;
  logic                 acierto, vuelta_completa, fin_timeout, cancela;

  // Both top bytes of the hash must be strictly below the target.
  assign acierto         = (hash_reg[HASH_W-1 -: 8] < target_reg) &&
                           (hash_reg[HASH_W-9 -: 8] < target_reg);
  assign nonce_sig       = nonce + NONCE_W'(1);
  // Next nonce would be the first one tried again: whole space covered.
  assign vuelta_completa = (nonce_sig == nonce_base_reg);
  assign fin_timeout     = (tcnt == T_LIM);
  assign cancela         = abortar && (estado != IDLE);

  assign hash_inicio = (estado == CARGA);
  assign hash_bloque = {bloque_reg, nonce};
  assign ocupado     = (estado != IDLE);

  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (inicio) estado_sig = CARGA;
      CARGA:   estado_sig = ESPERA;
      ESPERA:  if (hash_terminado)   estado_sig = EVALUA;
               else if (fin_timeout) estado_sig = IDLE;
      EVALUA:  estado_sig = (acierto || vuelta_completa) ? IDLE : CARGA;
      default: estado_sig = IDLE;
    endcase
    if (cancela) estado_sig = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bloque_reg     <= '0;
      target_reg     <= '0;
      nonce_base_reg <= '0;
      nonce          <= '0;
      hash_reg       <= '0;
      tcnt           <= '0;
      terminado      <= 1'b0;
      encontrado     <= 1'b0;
      agotado        <= 1'b0;
      error_timeout  <= 1'b0;
      nonce_ganador  <= '0;
      hash_ganador   <= '0;
      intentos       <= '0;
    end else begin
      terminado <= 1'b0;
      // An abort freezes everything: no pulse, flags and intentos keep their value.
      if (!cancela) begin
        case (estado)
          IDLE: if (inicio) begin
            bloque_reg     <= bloque_datos;
            target_reg     <= target;
            nonce_base_reg <= nonce_base;
            nonce          <= nonce_base;
            intentos       <= '0;
            encontrado     <= 1'b0;
            agotado        <= 1'b0;
            error_timeout  <= 1'b0;
            nonce_ganador  <= '0;
            hash_ganador   <= '0;
          end
          CARGA: tcnt <= '0;
          ESPERA: begin
            tcnt <= tcnt + TW'(1);
            if (hash_terminado) begin
              hash_reg <= hash_resultado;
              if (intentos != INT_MAX) intentos <= intentos + (NONCE_W+1)'(1);
            end else if (fin_timeout) begin
              error_timeout <= 1'b1;
              terminado     <= 1'b1;
            end
          end
          EVALUA: begin
            if (acierto) begin
              encontrado    <= 1'b1;
              nonce_ganador <= nonce;
              hash_ganador  <= hash_reg;
              terminado     <= 1'b1;
            end else if (vuelta_completa) begin
              agotado   <= 1'b1;
              terminado <= 1'b1;
            end else begin
              nonce <= nonce_sig;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controlador_nonce.sv
// Directed bench for controlador_nonce. Instance A uses default parameters
// (hit, strict compare, abort, reset, ignored inputs); instance B uses
// NONCE_W=4, TIMEOUT_CICLOS=8 (exhaustion with wrap, timeout). Each instance
// has a small hash core model with latency 3.
module tb_controlador_nonce;

  localparam logic [95:0] BLK = 96'h397d9f2f40ca9e6c6b1f3324;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------- instance A
  logic         ini_a, abo_a, hi_a, ht_a, ocu_a, term_a, enc_a, ago_a, eto_a;
  logic [95:0]  blk_a;
  logic [7:0]   tgt_a;
  logic [31:0]  nb_a, ng_a;
  logic [127:0] hb_a;
  logic [23:0]  hr_a, hg_a;
  logic [32:0]  int_a;

  controlador_nonce dut_a (
    .clk(clk), .reset(reset), .inicio(ini_a), .abortar(abo_a),
    .bloque_datos(blk_a), .target(tgt_a), .nonce_base(nb_a),
    .hash_inicio(hi_a), .hash_bloque(hb_a), .hash_terminado(ht_a),
    .hash_resultado(hr_a), .ocupado(ocu_a), .terminado(term_a),
    .encontrado(enc_a), .agotado(ago_a), .error_timeout(eto_a),
    .nonce_ganador(ng_a), .hash_ganador(hg_a), .intentos(int_a)
  );

  // ---------------- instance B
  logic         ini_b, abo_b, hi_b, ht_b, ocu_b, term_b, enc_b, ago_b, eto_b;
  logic [95:0]  blk_b;
  logic [7:0]   tgt_b;
  logic [3:0]   nb_b, ng_b;
  logic [99:0]  hb_b;
  logic [23:0]  hr_b, hg_b;
  logic [4:0]   int_b;

  controlador_nonce #(.NONCE_W(4), .HASH_W(24), .TIMEOUT_CICLOS(8)) dut_b (
    .clk(clk), .reset(reset), .inicio(ini_b), .abortar(abo_b),
    .bloque_datos(blk_b), .target(tgt_b), .nonce_base(nb_b),
    .hash_inicio(hi_b), .hash_bloque(hb_b), .hash_terminado(ht_b),
    .hash_resultado(hr_b), .ocupado(ocu_b), .terminado(term_b),
    .encontrado(enc_b), .agotado(ago_b), .error_timeout(eto_b),
    .nonce_ganador(ng_b), .hash_ganador(hg_b), .intentos(int_b)
  );

  // ---------------- core model A: done pulse 3 cycles after the start cycle
  int          mode_a = 0;
  logic [31:0] base_a = 32'h0;
  logic [1:0]  cnt_a;
  logic [31:0] nl_a;
  logic        htm_a = 1'b0;
  logic [23:0] hrm_a = 24'h0;
  logic        inj_en = 1'b0;
  logic        ht_force = 1'b0;

  function automatic logic [23:0] resp_a(input logic [31:0] n);
    if (mode_a == 0) return (n == 32'h103) ? 24'h0509AA : 24'hFFFFFF;
    return (n == base_a + 32'd2) ? 24'h090900 : 24'h0A0000;
  endfunction

  always @(posedge clk) begin
    htm_a <= 1'b0;
    if (reset) cnt_a <= 2'd0;
    else if (hi_a) begin
      cnt_a <= 2'd2;
      nl_a  <= hb_a[31:0];
    end else if (cnt_a != 2'd0) begin
      cnt_a <= cnt_a - 2'd1;
      if (cnt_a == 2'd1) begin
        htm_a <= 1'b1;
        hrm_a <= resp_a(nl_a);
      end
    end
  end

  // Spurious done pulse (with a winning hash) spanning the CARGA sampling edge.
  always @(negedge clk) ht_force <= inj_en && hi_a;

  assign ht_a = htm_a | ht_force;
  assign hr_a = ht_force ? 24'h0509AA : hrm_a;

  // ---------------- core model B: always FFFFFF (mode 0) or never answers (mode 1)
  int         mode_b = 0;
  logic [1:0] cnt_b;
  logic       htm_b = 1'b0;

  always @(posedge clk) begin
    htm_b <= 1'b0;
    if (reset) cnt_b <= 2'd0;
    else if (hi_b) cnt_b <= (mode_b == 0) ? 2'd2 : 2'd0;
    else if (cnt_b != 2'd0) begin
      cnt_b <= cnt_b - 2'd1;
      if (cnt_b == 2'd1) htm_b <= 1'b1;
    end
  end

  assign ht_b = htm_b;
  assign hr_b = 24'hFFFFFF;

  // ---------------- checking
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0] exp_n;
  logic       seq_en = 1'b0;
  int         seq_cnt = 0;

  task automatic wait_a(output int n);
    n = 0;
    while (!term_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!term_a) chk("wait_a_bound", term_a, 1'b1);
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!term_b && n < 400) begin
      if (seq_en && hi_b) begin
        chk("seq_nonce", hb_b[3:0], exp_n);
        exp_n = exp_n + 4'd1;
        seq_cnt++;
      end
      @(negedge clk);
      n++;
    end
    if (!term_b) chk("wait_b_bound", term_b, 1'b1);
  endtask

  // Returns at the negedge of the CARGA cycle.
  task automatic start_a(input logic [31:0] base, input logic [7:0] tgt);
    @(negedge clk);
    ini_a = 1'b1; blk_a = BLK; tgt_a = tgt; nb_a = base; base_a = base;
    @(negedge clk);
    ini_a = 1'b0;
  endtask

  task automatic start_b(input logic [3:0] base);
    @(negedge clk);
    ini_b = 1'b1; blk_b = BLK; tgt_b = 8'h0a; nb_b = base;
    @(negedge clk);
    ini_b = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    ini_a = 0; abo_a = 0; blk_a = '0; tgt_a = '0; nb_a = '0;
    ini_b = 0; abo_b = 0; blk_b = '0; tgt_b = '0; nb_b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ocupado_a", ocu_a, 0);
    chk("rst_hash_bloque_a", hb_a, 0);
    chk("rst_intentos_a", int_a, 0);
    chk("rst_flags_a", {term_a, enc_a, ago_a, eto_a, hi_a}, 0);
    chk("rst_ocupado_b", ocu_b, 0);
    chk("rst_hash_bloque_b", hb_b, 0);
    reset = 1'b0;

    // Hit at 0x103, 4 attempts of 5 cycles.
    mode_a = 0;
    start_a(32'h100, 8'h0a);
    chk("carga_hash_inicio", hi_a, 1);
    chk("carga_hash_bloque", hb_a, {BLK, 32'h100});
    chk("carga_ocupado", ocu_a, 1);
    wait_a(n);
    chk("hit_latencia", n, 20);
    chk("hit_encontrado", enc_a, 1);
    chk("hit_nonce", ng_a, 32'h103);
    chk("hit_hash", hg_a, 24'h0509AA);
    chk("hit_intentos", int_a, 4);
    chk("hit_ocupado", ocu_a, 0);
    chk("hit_otros_flags", {ago_a, eto_a}, 0);
    @(negedge clk);
    chk("hit_pulso_1ciclo", term_a, 0);
    chk("hit_sticky", enc_a, 1);

    // Strict compare: 0x0A is not below 0x0A; hit at base+2.
    mode_a = 1;
    start_a(32'h2000, 8'h0a);
    wait_a(n);
    chk("estricto_latencia", n, 15);
    chk("estricto_nonce", ng_a, 32'h2002);
    chk("estricto_hash", hg_a, 24'h090900);
    chk("estricto_intentos", int_a, 3);

    // Abort in the second attempt's ESPERA.
    mode_a = 0;
    start_a(32'h100, 8'h0a);
    repeat (6) @(negedge clk);
    chk("abort_previo_ocupado", ocu_a, 1);
    abo_a = 1'b1;
    @(negedge clk);
    abo_a = 1'b0;
    chk("abort_ocupado", ocu_a, 0);
    chk("abort_flags", {term_a, enc_a, ago_a, eto_a}, 0);
    chk("abort_intentos", int_a, 1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (term_a) seen = 1'b1;
    end
    chk("abort_sin_terminado", seen, 0);

    // Reset mid-search, then a clean restart.
    start_a(32'h100, 8'h0a);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_ocupado", ocu_a, 0);
    chk("rstmid_hash_bloque", hb_a, 0);
    chk("rstmid_intentos", int_a, 0);
    chk("rstmid_resultados", {ng_a, hg_a, term_a, enc_a}, 0);
    start_a(32'h100, 8'h0a);
    chk("reinicio_hash_bloque", hb_a, {BLK, 32'h100});
    chk("reinicio_intentos", int_a, 0);
    wait_a(n);
    chk("reinicio_latencia", n, 20);
    chk("reinicio_nonce", ng_a, 32'h103);
    repeat (3) @(negedge clk);

    // inicio held and inputs changed while busy; spurious done during CARGA.
    inj_en = 1'b1;
    @(negedge clk);
    ini_a = 1'b1; blk_a = BLK; tgt_a = 8'h0a; nb_a = 32'h100;
    @(negedge clk);
    blk_a = ~BLK; tgt_a = 8'h00; nb_a = 32'h5;
    repeat (10) @(negedge clk);
    ini_a = 1'b0;
    wait_a(n);
    inj_en = 1'b0;
    chk("ignora_latencia", n, 10);
    chk("ignora_nonce", ng_a, 32'h103);
    chk("ignora_hash", hg_a, 24'h0509AA);
    chk("ignora_intentos", int_a, 4);
    chk("ignora_hash_bloque", hb_a, {BLK, 32'h103});

    // Exhaustion with wrap on the 4-bit instance.
    mode_b = 0;
    exp_n = 4'hE;
    seq_en = 1'b1;
    start_b(4'hE);
    wait_b(n);
    seq_en = 1'b0;
    chk("agot_latencia", n, 80);
    chk("agot_intentos_vistos", seq_cnt, 16);
    chk("agot_agotado", ago_b, 1);
    chk("agot_encontrado", enc_b, 0);
    chk("agot_intentos", int_b, 16);
    chk("agot_ocupado", ocu_b, 0);

    // Timeout: core never answers.
    mode_b = 1;
    start_b(4'h3);
    wait_b(n);
    chk("timeout_latencia", n, 9);
    chk("timeout_flag", eto_b, 1);
    chk("timeout_agotado", ago_b, 0);
    chk("timeout_intentos", int_b, 0);
    chk("timeout_ocupado", ocu_b, 0);
    @(negedge clk);
    chk("timeout_pulso", term_b, 0);
    chk("timeout_sticky", eto_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/controlador_nonce.md
Name: controlador_nonce

Overview:
Sequencer that drives one micro_ucr_hash core to search for a winning nonce.
- Latches the 96-bit data block, the target and a starting nonce.
- Feeds {bloque_datos, nonce} to the core, waits for its completion, compares the hash against the target, and steps the nonce.
- Stops on a hit, when the nonce space is exhausted, on core timeout, or on abort.
- Sits between the top-level/testbench control (inicio/target) and the hash core.

Parameters:
NONCE_W, 32, nonce width in bits
HASH_W, 24, width of hash_resultado from the core
TIMEOUT_CICLOS, 255, max cycles to wait for hash_terminado per attempt (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
inicio  input  1  start request; accepted only in IDLE
abortar  input  1  cancel search; effective in any non-IDLE state
bloque_datos  input  96  data block (12 bytes)
target  input  8  difficulty target
nonce_base  input  NONCE_W  first nonce to try
hash_inicio  output  1  one-cycle start pulse to hash core
hash_bloque  output  96+NONCE_W  {bloque_reg, nonce} to core
hash_terminado  input  1  core done pulse
hash_resultado  input  HASH_W  core hash, valid with hash_terminado
ocupado  output  1  high while not in IDLE
terminado  output  1  one-cycle pulse when search ends (hit/exhausted/timeout)
encontrado  output  1  sticky: last search found a nonce
agotado  output  1  sticky: full nonce space tried, no hit
error_timeout  output  1  sticky: core did not respond
nonce_ganador  output  NONCE_W  winning nonce
hash_ganador  output  HASH_W  winning hash
intentos  output  NONCE_W+1  completed hash attempts in current/last search

Behaviour:
- Reset (sync, any state, including mid-search):
  - state=IDLE.
  - All outputs and internal registers 0.
  - hash_bloque=0.
- States: IDLE, CARGA, ESPERA, EVALUA.
- IDLE:
  - On inicio=1, latch bloque_datos, target and nonce_base into registers.
  - nonce<=nonce_base; intentos<=0; clear encontrado/agotado/error_timeout/nonce_ganador/hash_ganador.
  - Next state CARGA.
- CARGA (1 cycle):
  - hash_inicio=1.
  - Clear timeout counter.
  - Next state ESPERA.
- hash_bloque is combinational from registers {bloque_reg, nonce}. It stays stable from CARGA until leaving EVALUA.
- ESPERA:
  - Timeout counter increments each cycle.
  - If hash_terminado=1: capture hash_resultado into hash_reg, intentos<=intentos+1, next state EVALUA.
  - Else if counter reaches TIMEOUT_CICLOS-1: error_timeout<=1, terminado pulse, next state IDLE.
  - If both happen in the same cycle, hash_terminado wins.
  - hash_terminado is ignored outside ESPERA.
- EVALUA (1 cycle). Hit = (hash_reg[HASH_W-1 -: 8] < target_reg) AND (hash_reg[HASH_W-9 -: 8] < target_reg). The comparison is strict and unsigned.
  - Hit: encontrado<=1, nonce_ganador<=nonce, hash_ganador<=hash_reg, terminado pulse, next state IDLE.
  - No hit and nonce+1 (mod 2^NONCE_W) == nonce_base_reg: agotado<=1, terminado pulse, next state IDLE.
  - Otherwise: nonce<=nonce+1 (wraps 2^NONCE_W-1 -> 0), next state CARGA.
- Per-attempt cost: with core latency L (hash_terminado L cycles after the hash_inicio cycle), one attempt takes L+2 cycles.
- terminado is registered. It is high exactly the first cycle back in IDLE; ocupado is 0 that same cycle.
- Sticky flags and nonce_ganador/hash_ganador hold until the next accepted inicio.
- abortar=1 in any non-IDLE state:
  - Next state IDLE, no terminado pulse, flags unchanged (remain 0).
  - intentos holds its last value.
  - abortar has priority over all other transitions. It is ignored in IDLE.
- inicio while ocupado=1 is ignored. Inputs are sampled only at acceptance.
- intentos saturates at 2^NONCE_W (full space) and never wraps.

Test Plan:
- Hit: bloque=39 7d 9f 2f 40 ca 9e 6c 6b 1f 33 24, target=0x0a, nonce_base=0x100, core model L=3 returning 24'hFFFFFF except 24'h0509AA for nonce 0x103 -> terminado pulse, encontrado=1, nonce_ganador=0x103, hash_ganador=0x0509AA, intentos=4, total 4*(3+2)=20 cycles from CARGA entry.
- Strict compare: model returns 24'h0A0000 for every nonce, then 24'h090900 at nonce_base+2 -> no hit on 0x0A, hit at base+2, intentos=3.
- Exhaustion with wrap: NONCE_W=4, nonce_base=0xE, model never hits -> nonces E,F,0..D tried in order, agotado=1, intentos=16, encontrado=0.
- Timeout: TIMEOUT_CICLOS=8, model never asserts hash_terminado -> error_timeout=1 and terminado exactly 8 cycles after ESPERA entry; ocupado=0 afterwards.
- Abort/reset mid-search: abortar during ESPERA -> IDLE next cycle, no terminado, flags 0. Repeat with reset=1 -> all outputs 0. A following inicio restarts from nonce_base with intentos=0.
- inicio held high during search and hash_terminado pulsed during CARGA -> both ignored; results match the hit scenario.
